nand_input_conditioner: RTL and testbench

Input conditioning stage that sits directly upstream of the NAND gate in the Tiny Tapeout user design. It takes the raw, asynchronous pad inputs (`ui_in[1:0]` at the top level) and passes each through a multi-flop synchronizer and a per-channel debouncer. It drives clean, glitch-free A/B levels into the gate, plus one-cycle rise/fall event pulses. The top-level wrapper drives `rst` from `~rst_n`.

---
 rtl/nand_io_pkg.sv | 17 +
 rtl/nand_input_conditioner_if.sv | 28 ++
 rtl/debounce_channel.sv | 103 ++++++++++
 rtl/nand_input_conditioner.sv | 72 +++++++
 tb/tb_nand_input_conditioner.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/nand_io_pkg.sv
// Shared types and constants for the NAND input conditioning stage.
package nand_io_pkg;

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } ch_state_t;

  localparam int unsigned SYNC_STAGES_D   = 2;
  localparam int unsigned STABLE_CYCLES_D = 16;

  // Counter must hold values up to STABLE_CYCLES.
  function automatic int unsigned cnt_width(input int unsigned stable_cycles);
    return (stable_cycles < 1) ? 1 : $clog2(stable_cycles + 1);
  endfunction

endpackage

// File: rtl/nand_input_conditioner_if.sv
// Raw pad inputs and conditioned level/pulse outputs of the input conditioner.
interface nand_input_conditioner_if #(
  parameter int unsigned N_CH = 2
) ();

  logic [N_CH-1:0] raw_in;
  logic [N_CH-1:0] clean_out;
  logic [N_CH-1:0] rise_pulse;
  logic [N_CH-1:0] fall_pulse;
  logic            settled;

  modport master (
    output raw_in,
    input  clean_out,
    input  rise_pulse,
    input  fall_pulse,
    input  settled
  );

  modport slave (
    input  raw_in,
    output clean_out,
    output rise_pulse,
    output fall_pulse,
    output settled
  );

endinterface

// File: rtl/debounce_channel.sv
// One input channel: multi-flop synchronizer, STABLE/PENDING debouncer and
// registered rise/fall pulses gated by the caller's pulse enable.
module debounce_channel
  import nand_io_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = SYNC_STAGES_D,
  parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_D
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_in,
  input  logic pulse_en,
  output logic clean,
  output logic rise,
  output logic fall,
  output logic pending_c
);

  localparam int unsigned CW = cnt_width(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  ch_state_t              state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   clean_q, clean_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   sync_lvl;
  logic                   commit;

  assign sync_lvl = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], raw_in};
    state_d = state_q;
    cnt_d   = cnt_q;
    clean_d = clean_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    commit  = 1'b0;

    case (state_q)
      STABLE: begin
        cnt_d = '0;
        if (sync_lvl != clean_q) begin
          if (STABLE_CYCLES == 1) begin
            commit = 1'b1;
          end else begin
            state_d = PENDING;
            cnt_d   = CW'(1);
          end
        end
      end
      PENDING: begin
        if (sync_lvl == clean_q) begin
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          commit = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = STABLE;
        cnt_d   = '0;
      end
    endcase

    // Accept the new level; pulses only once the power-up hold-off is over.
    if (commit) begin
      clean_d = sync_lvl;
      state_d = STABLE;
      cnt_d   = '0;
      rise_d  = pulse_en & sync_lvl;
      fall_d  = pulse_en & ~sync_lvl;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      state_q <= STABLE;
      cnt_q   <= '0;
      clean_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign clean     = clean_q;
  assign rise      = rise_q;
  assign fall      = fall_q;
  assign pending_c = (state_q == PENDING);

endmodule

// File: rtl/nand_input_conditioner.sv
// Conditions the raw pad inputs feeding the NAND gate: per-channel debouncers
// plus a shared power-up hold-off that masks pulses and drives settled.
module nand_input_conditioner
  import nand_io_pkg::*;
#(
  parameter int unsigned N_CH          = 2,
  parameter int unsigned SYNC_STAGES   = SYNC_STAGES_D,
  parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_D
) (
  input  logic                     clk,
  input  logic                     rst,
  nand_input_conditioner_if.slave  io
);

  localparam int unsigned HOLD = SYNC_STAGES + STABLE_CYCLES + 1;
  localparam int unsigned HW   = $clog2(HOLD + 1);

  logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
  logic            holdoff_done_q, holdoff_done_d;
  logic            settled_q, settled_d;
  logic [N_CH-1:0] clean_w;
  logic [N_CH-1:0] rise_w;
  logic [N_CH-1:0] fall_w;
  logic [N_CH-1:0] pending_w;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES   (SYNC_STAGES),
      .STABLE_CYCLES (STABLE_CYCLES)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .raw_in    (io.raw_in[i]),
      .pulse_en  (holdoff_done_q),
      .clean     (clean_w[i]),
      .rise      (rise_w[i]),
      .fall      (fall_w[i]),
      .pending_c (pending_w[i])
    );
  end

  // Hold-off counter freezes once done; done is sticky until reset.
  always_comb begin
    hold_cnt_d     = hold_cnt_q;
    holdoff_done_d = holdoff_done_q;
    if (!holdoff_done_q) begin
      hold_cnt_d = hold_cnt_q + HW'(1);
      if (hold_cnt_q == HW'(HOLD - 1)) begin
        holdoff_done_d = 1'b1;
      end
    end
    settled_d = holdoff_done_q & ~(|pending_w);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt_q     <= '0;
      holdoff_done_q <= 1'b0;
      settled_q      <= 1'b0;
    end else begin
      hold_cnt_q     <= hold_cnt_d;
      holdoff_done_q <= holdoff_done_d;
      settled_q      <= settled_d;
    end
  end

  assign io.clean_out  = clean_w;
  assign io.rise_pulse = rise_w;
  assign io.fall_pulse = fall_w;
  assign io.settled    = settled_q;

endmodule

// File: tb/tb_nand_input_conditioner.sv
// Directed bench: stimulus pushes expected pulse events, a monitor pops them.
module tb_nand_input_conditioner;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned cyc = 0;
  int unsigned total = 0;
  int unsigned bad = 0;
  bit mon_en = 1'b0;

  typedef struct {
    int unsigned cyc;
    logic [1:0]  rise;
    logic [1:0]  fall;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  nand_input_conditioner_if #(.N_CH(2)) io ();

  nand_input_conditioner #(
    .N_CH          (2),
    .SYNC_STAGES   (2),
    .STABLE_CYCLES (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .io  (io.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Every pulse the DUT shows must match the next expected event.
  always @(negedge clk) begin
    if (mon_en && ((|io.rise_pulse) || (|io.fall_pulse))) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pulse cyc=%0d rise=%b fall=%b", cyc, io.rise_pulse, io.fall_pulse);
      end else begin
        mon_e = q.pop_front();
        if (mon_e.cyc != cyc || mon_e.rise !== io.rise_pulse || mon_e.fall !== io.fall_pulse) begin
          bad++;
          $display("FAIL pulse_event got cyc=%0d rise=%b fall=%b want cyc=%0d rise=%b fall=%b",
                   cyc, io.rise_pulse, io.fall_pulse, mon_e.cyc, mon_e.rise, mon_e.fall);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_pulse(input int unsigned at, input logic [1:0] r, input logic [1:0] f);
    exp_t e;
    e.cyc  = at;
    e.rise = r;
    e.fall = f;
    q.push_back(e);
  endtask

  task automatic hold_ch1_low(input int n);
    for (int i = 0; i < n; i++) begin
      step(1);
      chk("t3_clean1_early", 32'(io.clean_out[1]), 32'd0);
    end
  endtask

  int unsigned base;

  initial begin
    io.raw_in = 2'b00;

    // 1: reset idle
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mon_en = 1'b1;
    chk("t1_rst_clean", 32'(io.clean_out), 32'd0);
    chk("t1_rst_settled", 32'(io.settled), 32'd0);
    step(2);
    rst = 1'b0;
    base = cyc;
    for (int k = 1; k <= 22; k++) begin
      step(1);
      chk("t1_clean", 32'(io.clean_out), 32'd0);
      chk("t1_settled", 32'(io.settled), (k >= 20) ? 32'd1 : 32'd0);
    end

    // 2: clean rise on channel 0
    io.raw_in = 2'b01;
    base = cyc;
    expect_pulse(base + 18, 2'b01, 2'b00);
    for (int k = 1; k <= 20; k++) begin
      step(1);
      chk("t2_clean0", 32'(io.clean_out[0]), (k >= 18) ? 32'd1 : 32'd0);
      if (k == 4 || k == 18) chk("t2_settled_low", 32'(io.settled), 32'd0);
      if (k == 19 || k == 20) chk("t2_settled_high", 32'(io.settled), 32'd1);
    end
    step(5);

    // 3: bounce on channel 1
    io.raw_in = 2'b11;
    hold_ch1_low(5);
    io.raw_in = 2'b01;
    hold_ch1_low(1);
    io.raw_in = 2'b11;
    hold_ch1_low(10);
    io.raw_in = 2'b01;
    hold_ch1_low(2);
    io.raw_in = 2'b11;
    base = cyc;
    expect_pulse(base + 18, 2'b10, 2'b00);
    for (int k = 1; k <= 18; k++) begin
      step(1);
      chk("t3_clean1", 32'(io.clean_out[1]), (k >= 18) ? 32'd1 : 32'd0);
    end
    step(5);

    // 4: simultaneous fall on ch0 and rise on ch1
    io.raw_in = 2'b01;
    base = cyc;
    expect_pulse(base + 18, 2'b00, 2'b10);
    step(22);
    chk("t4_pre_clean", 32'(io.clean_out), 32'h1);
    io.raw_in = 2'b10;
    base = cyc;
    expect_pulse(base + 18, 2'b10, 2'b01);
    for (int k = 1; k <= 18; k++) begin
      step(1);
      if (k == 17) chk("t4_clean_before", 32'(io.clean_out), 32'h1);
      if (k == 18) chk("t4_clean_after", 32'(io.clean_out), 32'h2);
    end
    step(5);

    // 5: inputs high through reset
    io.raw_in = 2'b11;
    rst = 1'b1;
    step(3);
    chk("t5_rst_clean", 32'(io.clean_out), 32'd0);
    chk("t5_rst_settled", 32'(io.settled), 32'd0);
    rst = 1'b0;
    for (int k = 1; k <= 21; k++) begin
      step(1);
      if (k == 17) chk("t5_clean_before", 32'(io.clean_out), 32'h0);
      if (k == 18) chk("t5_clean_after", 32'(io.clean_out), 32'h3);
      if (k == 19) chk("t5_settled_low", 32'(io.settled), 32'd0);
      if (k == 20) chk("t5_settled_high", 32'(io.settled), 32'd1);
    end
    step(3);

    // 6: reset mid-PENDING
    io.raw_in = 2'b10;
    base = cyc;
    expect_pulse(base + 18, 2'b00, 2'b01);
    step(22);
    io.raw_in = 2'b11;
    step(9);
    chk("t6_clean0_pending", 32'(io.clean_out[0]), 32'd0);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("t6_clean0_reset", 32'(io.clean_out[0]), 32'd0);
    for (int k = 1; k <= 20; k++) begin
      step(1);
      if (k == 17) chk("t6_clean_before", 32'(io.clean_out), 32'h0);
      if (k == 18) chk("t6_clean_after", 32'(io.clean_out), 32'h3);
    end
    step(5);

    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
